// File: rtl/fifo_rr_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

   // Wrapped increment of a producer pointer, valid for any producer count.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
      return (ptr + 1 >= num_req) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// Round-robin winner search: first requester after last_grant, with wrap-around.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic [IDW-1:0]     winner,
   output logic               any_req
);

   logic [IDW-1:0] cursor;
   logic           found;

   // Walk the ring once starting just after last_grant; the first active request wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cursor = IDW'(rr_next(32'(last_grant), NUM_REQ));
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[cursor]) begin
            winner = cursor;
            found  = 1'b1;
         end
         cursor = IDW'(rr_next(32'(cursor), NUM_REQ));
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready producers, granting
// round-robin bursts of up to MAX_BURST beats and never writing while full.
module fifo_rr_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATAWIDTH = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         fifo_full,
   output logic                         fifo_write_en,
   output logic [DATAWIDTH-1:0]         fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

   arb_state_t     state, state_next;
   logic [IDW-1:0] grant_next;
   logic [IDW-1:0] last_grant, last_grant_next;
   logic [IDW-1:0] winner;
   logic [CW-1:0]  beat_cnt, beat_cnt_next;
   logic           any_req;
   logic           cur_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign cur_valid = req_valid[grant_id];

   // State register; last_grant starts at the top so producer 0 wins the first round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         grant_id   <= '0;
         last_grant <= LAST_ID;
         beat_cnt   <= '0;
      end else begin
         state      <= state_next;
         grant_id   <= grant_next;
         last_grant <= last_grant_next;
         beat_cnt   <= beat_cnt_next;
      end
   end

   // Next-state: arbitrate from IDLE; in a burst, release on drop or last beat, hold on full.
   always_comb begin
      state_next      = state;
      grant_next      = grant_id;
      last_grant_next = last_grant;
      beat_cnt_next   = beat_cnt;
      case (state)
         ARB_IDLE: begin
            if (any_req) begin
               state_next    = ARB_BURST;
               grant_next    = winner;
               beat_cnt_next = '0;
            end
         end
         ARB_BURST: begin
            if (!cur_valid) begin
               state_next      = ARB_IDLE;
               last_grant_next = grant_id;
            end else if (fifo_full) begin
               state_next = ARB_BURST;
            end else if (beat_cnt == LAST_BEAT) begin
               state_next      = ARB_IDLE;
               last_grant_next = grant_id;
            end else begin
               beat_cnt_next = beat_cnt + 1'b1;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Outputs: zero-latency pass-through of the granted producer, gated by the full flag.
   always_comb begin
      req_ready     = '0;
      fifo_write_en = 1'b0;
      fifo_data_in  = '0;
      busy          = 1'b0;
      if (state == ARB_BURST) begin
         busy                = 1'b1;
         req_ready[grant_id] = !fifo_full;
         fifo_write_en       = cur_valid && !fifo_full;
         fifo_data_in        = req_data[grant_id*DATAWIDTH +: DATAWIDTH];
      end
   end

   a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_write_en && fifo_full));

   a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Scoreboard bench for fifo_rr_write_arbiter: a high-level round-robin model
// predicts each cycle's outputs and the written beats; a monitor compares.
`timescale 1ns/1ps
module tb_fifo_rr_write_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;
   localparam int IDW       = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  fifo_full;
   logic                  fifo_write_en;
   logic [DW-1:0]         fifo_data_in;
   logic [IDW-1:0]        grant_id;
   logic                  busy;

   typedef struct {
      logic [NUM_REQ-1:0] ready;
      logic               we;
      int                 grant;
      logic               busy;
      logic [DW-1:0]      data;
   } stat_t;

   stat_t         stat_q[$];
   logic [DW-1:0] data_q[$];
   int            grant_log[$];
   int            we_log[$];
   int            data_log[$];
   logic          prev_busy = 1'b0;
   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] prod_base[NUM_REQ];
   logic [DW-1:0] prod_seq[NUM_REQ];
   int            acc_cnt[NUM_REQ];
   int            m_busy, m_grant, m_last, m_beats;

   fifo_rr_write_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATAWIDTH (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_seq(input string name, input int act[$], input int exp[$]);
      checkOutput({name, "_len"}, act.size(), exp.size());
      for (int i = 0; i < act.size() && i < exp.size(); i++)
         checkOutput($sformatf("%s[%0d]", name, i), act[i], exp[i]);
   endtask

   function automatic logic [DW-1:0] cur_data(input int p);
      return prod_base[p] + prod_seq[p];
   endfunction

   task automatic drive_data();
      for (int i = 0; i < NUM_REQ; i++)
         req_data[i*DW +: DW] = cur_data(i);
   endtask

   // Reference: producer chosen by scanning (last+k) mod N, bursts counted in beats.
   task automatic model_step();
      stat_t st;
      st.ready = '0;
      st.we    = 1'b0;
      st.data  = '0;
      if (!rst_n) begin
         m_busy = 0; m_grant = 0; m_last = NUM_REQ - 1; m_beats = 0;
         st.grant = 0;
         st.busy  = 1'b0;
      end else if (m_busy == 0) begin
         st.grant = m_grant;
         st.busy  = 1'b0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_last + k) % NUM_REQ;
            if (req_valid[c]) begin
               m_grant = c; m_busy = 1; m_beats = 0;
               break;
            end
         end
      end else begin
         st.grant = m_grant;
         st.busy  = 1'b1;
         st.data  = cur_data(m_grant);
         if (!fifo_full) st.ready[m_grant] = 1'b1;
         if (req_valid[m_grant] && !fifo_full) begin
            st.we = 1'b1;
            data_q.push_back(cur_data(m_grant));
            prod_seq[m_grant] = prod_seq[m_grant] + 1'b1;
            acc_cnt[m_grant]++;
         end
         if (!req_valid[m_grant]) begin
            m_last = m_grant; m_busy = 0;
         end else if (!fifo_full) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
               m_last = m_grant; m_busy = 0;
            end
         end
      end
      stat_q.push_back(st);
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic full, input logic rstn);
      @(negedge clk);
      rst_n     = rstn;
      req_valid = v;
      fifo_full = full;
      drive_data();
      #1;
      model_step();
   endtask

   task automatic start_test(input string name);
      $display("[TB] %s", name);
      for (int i = 0; i < NUM_REQ; i++) begin
         prod_seq[i] = '0;
         acc_cnt[i]  = 0;
      end
      applyStimulus('0, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b1);
      #5;
      grant_log.delete();
      we_log.delete();
      data_log.delete();
   endtask

   // Monitor: compare DUT outputs against the model each cycle, shortly before the rising edge.
   always @(negedge clk) begin
      stat_t st;
      #3;
      if (stat_q.size() > 0) begin
         st = stat_q.pop_front();
         checkOutput("req_ready", int'(req_ready), int'(st.ready));
         checkOutput("write_en", int'(fifo_write_en), int'(st.we));
         checkOutput("grant_id", int'(grant_id), st.grant);
         checkOutput("busy", int'(busy), int'(st.busy));
         checkOutput("data_in", int'(fifo_data_in), int'(st.data));
         checkOutput("write_while_full", int'(fifo_write_en && fifo_full), 0);
         checkOutput("ready_onehot0", int'($onehot0(req_ready)), 1);
         if (fifo_write_en) begin
            data_log.push_back(int'(fifo_data_in));
            if (data_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write at %0t", fifo_data_in, $time);
            end else begin
               checkOutput("scoreboard_data", int'(fifo_data_in), int'(data_q.pop_front()));
            end
         end
         we_log.push_back(int'(fifo_write_en));
         if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
         prev_busy = busy;
      end
   end

   initial begin
      logic [NUM_REQ-1:0] rv;
      logic               rf;
      int                 n;
      int                 sum;
      rst_n     = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      req_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         prod_base[i] = DW'(i * 16);
         prod_seq[i]  = '0;
         acc_cnt[i]   = 0;
      end
      m_busy = 0; m_grant = 0; m_last = NUM_REQ - 1; m_beats = 0;

      start_test("single producer, burst split 4+2");
      prod_base[2] = 8'hA0;
      n = 0;
      while (acc_cnt[2] < 6 && n < 40) begin
         applyStimulus(4'b0100, 1'b0, 1'b1);
         n++;
      end
      applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      checkOutput("t1_beats", acc_cnt[2], 6);
      check_seq("t1_grants", grant_log, '{2, 2});
      check_seq("t1_write_en", we_log, '{0, 1, 1, 1, 1, 0, 1, 1, 0});
      check_seq("t1_data", data_log, '{'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5});

      start_test("all producers valid, fairness");
      for (int c = 0; c < 25; c++) applyStimulus(4'b1111, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      sum = 0;
      foreach (we_log[i]) sum += we_log[i];
      checkOutput("t2_writes", sum, 20);
      check_seq("t2_grants", grant_log, '{0, 1, 2, 3, 0});

      start_test("fifo_full stall mid-burst");
      n = 0;
      while (acc_cnt[1] < 2 && n < 20) begin
         applyStimulus(4'b0010, 1'b0, 1'b1);
         n++;
      end
      for (int c = 0; c < 3; c++) applyStimulus(4'b0010, 1'b1, 1'b1);
      n = 0;
      while (acc_cnt[1] < 4 && n < 20) begin
         applyStimulus(4'b0010, 1'b0, 1'b1);
         n++;
      end
      applyStimulus(4'b0000, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      check_seq("t3_write_en", we_log, '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0});
      check_seq("t3_grants", grant_log, '{1});

      start_test("producer 3 drops valid, wrap to 0");
      for (int c = 0; c < 3; c++) applyStimulus(4'b1000, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) applyStimulus(4'b0001, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      check_seq("t4_grants", grant_log, '{3, 0});
      check_seq("t4_write_en", we_log, '{0, 1, 1, 0, 0, 1, 1, 0});
      checkOutput("t4_grant_hold", int'(grant_id), 0);

      start_test("reset mid-burst");
      for (int c = 0; c < 3; c++) applyStimulus(4'b0100, 1'b0, 1'b1);
      applyStimulus(4'b0100, 1'b0, 1'b0);
      checkOutput("t5_async_ready", int'(req_ready), 0);
      checkOutput("t5_async_we", int'(fifo_write_en), 0);
      applyStimulus(4'b0100, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'b1111, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      check_seq("t5_grants", grant_log, '{2, 0});

      start_test("random valid/full stimulus");
      for (int i = 0; i < NUM_REQ; i++) prod_base[i] = DW'(i * 64);
      rv = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rv[i]) rv[i] = ($urandom_range(7) != 0);
            else       rv[i] = ($urandom_range(1) == 1);
         end
         rf = ($urandom_range(3) == 0);
         applyStimulus(rv, rf, 1'b1);
      end
      for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b0, 1'b1);
      #5;
      checkOutput("drain", data_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
Shares one synchronous FIFO write port between NUM_REQ producers. Each producer uses a valid/ready handshake. The block grants one producer at a time, round-robin, for a burst of up to MAX_BURST beats. It drives the FIFO write_en/data_in and stalls on the FIFO full flag. It sits directly in front of the team's sync FIFO, so no producer ever writes while the FIFO is full.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATAWIDTH, 8, data bits per beat; must match the FIFO
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-producer data valid
req_data  input  NUM_REQ*DATAWIDTH  packed producer data; producer i uses bits [i*DATAWIDTH +: DATAWIDTH]
req_ready  output  NUM_REQ  per-producer accept; at most one bit high
fifo_full  input  1  full flag from the FIFO
fifo_write_en  output  1  FIFO write strobe
fifo_data_in  output  DATAWIDTH  FIFO write data
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted producer
busy  output  1  high while in ARB_BURST

Behaviour:
- Reset (async assert, sync release):
  - state=ARB_IDLE, grant_id=0, last_grant=NUM_REQ-1 (producer 0 has first priority), beat_cnt=0.
  - Outputs: req_ready=0, fifo_write_en=0, busy=0, fifo_data_in=0.
- Beat transfer: producer g is accepted in a cycle when req_valid[g] && req_ready[g].
- Outputs in ARB_BURST with grant g:
  - req_ready[g] = !fifo_full; all other bits 0.
  - fifo_write_en = req_valid[g] && !fifo_full.
  - fifo_data_in = req_data slice g.
  - All outputs are combinational from the registered state; there is no data pipeline stage (zero-latency pass-through).
- Outputs in ARB_IDLE: req_ready=0, fifo_write_en=0, fifo_data_in=0.
- ARB_IDLE -> ARB_BURST:
  - Taken when any req_valid is high.
  - The winner is the first requester with req_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - grant_id <= winner and beat_cnt <= 0.
  - Arbitration costs 1 cycle: the first beat can transfer in the cycle after the request is seen.
- ARB_BURST, each cycle, in priority order:
  - a) req_valid[g]=0: release. No transfer; last_grant<=g; go to ARB_IDLE.
  - b) fifo_full=1: stall. Hold state; beat_cnt unchanged; a stall never counts as a beat.
  - c) Transfer with beat_cnt==MAX_BURST-1: release. last_grant<=g; go to ARB_IDLE.
  - d) Transfer otherwise: beat_cnt<=beat_cnt+1.
- A release always passes through ARB_IDLE (one bubble cycle). This guarantees every other requester sees a new arbitration round.
- Fairness: with all requesters continuously valid and the FIFO never full, grants cycle 0,1,2,3,0,...; each grant carries MAX_BURST beats.
- Width rules:
  - beat_cnt width is $clog2(MAX_BURST+1).
  - The pointer increment wraps modulo NUM_REQ; this must also be correct when NUM_REQ is not a power of 2.
- Invariant: fifo_write_en && fifo_full is never 1. Bind this as a concurrent assertion in the block, disabled during reset.
- Invariant: $onehot0(req_ready) always holds (assertion).
- Reset mid-burst: all state returns to the reset values immediately. A beat presented in the reset cycle is not written.
- grant_id holds its last value while in ARB_IDLE.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
  - function rr_next(ptr, NUM_REQ) returning the wrapped increment
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector, last_grant.
  - Outputs: winner index and any_req.
  - Instantiated once.
- The FSM, beat counter and output mux live in the top module.

Test Plan:
- Single producer, NUM_REQ=4, MAX_BURST=4: req_valid=4'b0100 held for 6 beats, data 0xA0..0xA5, fifo_full=0.
  - Expected: grant_id=2; 0xA0..0xA3 written on 4 consecutive cycles.
  - Then 1 IDLE bubble, re-grant to 2, and 0xA4..0xA5 written.
- All four producers valid, never full.
  - Expected: grant order 0,1,2,3,0.
  - Each grant writes exactly 4 beats; fifo_write_en duty is 4 of every 5 cycles.
- fifo_full asserted for 3 cycles mid-burst, after beat 2 of producer 1.
  - Expected: req_ready[1]=0 and fifo_write_en=0 during those 3 cycles; beat_cnt held.
  - After fifo_full drops, beats 3 and 4 complete, then release.
- Producer 3 drops valid after 2 beats with producer 0 pending.
  - Expected: release at the drop cycle, IDLE, then grant_id=0 (wrap from 3).
- rst_n pulled low mid-burst on producer 2.
  - Expected: req_ready=0 and fifo_write_en=0 asynchronously.
  - After release, with 4'b1111 valid, the first grant goes to producer 0.
- Assertion check: random valid/full stimulus over 10k cycles.
  - Expected: no fifo_write_en && fifo_full and no multi-hot req_ready.
  - Every accepted beat appears on fifo_data_in in producer order.
